// File: rtl/pc_redirect_unit_pkg.sv
// Shared types and defaults for the PC redirect unit and its branch target generator.
package pc_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_J    = 3'd3,
    BR_JAL  = 3'd4,
    BR_JR   = 3'd5
  } br_type_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY_DEF = 32'h0000_4180;

  function automatic logic [31:0] sext_word_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_redirect_unit_branch_target_gen.sv
// Combinational branch/jump resolution: taken flag and 32-bit target.
// PC_ALIGN_CHECK_EN routes misaligned JR targets to EXC_ENTRY and flags adel_o.
module branch_target_gen
  import pc_pkg::*;
#(
  parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEF
) (
  input  logic [2:0]  br_type_i,
  input  logic        equal_i,
  input  logic [31:0] id_pc_i,
  input  logic [15:0] imm16_i,
  input  logic [25:0] instr_index_i,
  input  logic [31:0] rs_val_i,
  output logic        taken_o,
  output logic [31:0] target_o
`ifdef PC_ALIGN_CHECK_EN
  , output logic      adel_o
`endif
);

  logic [31:0] seq_pc;

  always_comb begin
    seq_pc   = id_pc_i + 32'd4;
    taken_o  = 1'b0;
    target_o = seq_pc;
`ifdef PC_ALIGN_CHECK_EN
    adel_o   = 1'b0;
`endif
    case (br_type_t'(br_type_i))
      BR_BEQ: begin
        taken_o  = equal_i;
        target_o = seq_pc + sext_word_offset(imm16_i);
      end
      BR_BNE: begin
        taken_o  = ~equal_i;
        target_o = seq_pc + sext_word_offset(imm16_i);
      end
      BR_J, BR_JAL: begin
        taken_o  = 1'b1;
        target_o = {seq_pc[31:28], instr_index_i, 2'b00};
      end
      BR_JR: begin
        taken_o  = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
        if (rs_val_i[1:0] != 2'b00) begin
          target_o = EXC_ENTRY;
          adel_o   = 1'b1;
        end else begin
          target_o = rs_val_i;
        end
`else
        target_o = rs_val_i & 32'hFFFF_FFFC;
`endif
      end
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// Program counter owner for the 5-stage MIPS pipeline with delay-slot redirect handling.
// Optional alignment check on JR targets: PC_ALIGN_CHECK_EN (adds adel_o).
module pc_redirect_unit
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_ack_i,
  input  logic        stall_i,
  input  logic        br_valid_i,
  input  logic [2:0]  br_type_i,
  input  logic        equal_i,
  input  logic [31:0] id_pc_i,
  input  logic [15:0] imm16_i,
  input  logic [25:0] instr_index_i,
  input  logic [31:0] rs_val_i,
  output logic [31:0] pc_o,
  output logic        fetch_req_o,
  output logic        redirect_o,
  output logic [31:0] link_o
`ifdef PC_ALIGN_CHECK_EN
  , output logic      adel_o
`endif
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        fetch_req_q, fetch_req_d;
  logic        redirect_q, redirect_d;
  logic        gen_taken;
  logic [31:0] gen_target;
  logic        taken;
  logic        advance;
`ifdef PC_ALIGN_CHECK_EN
  logic        gen_adel;
  logic        adel_q, adel_d;
`endif

  branch_target_gen #(
    .EXC_ENTRY(EXC_ENTRY)
  ) u_tgt (
    .br_type_i    (br_type_i),
    .equal_i      (equal_i),
    .id_pc_i      (id_pc_i),
    .imm16_i      (imm16_i),
    .instr_index_i(instr_index_i),
    .rs_val_i     (rs_val_i),
    .taken_o      (gen_taken),
    .target_o     (gen_target)
`ifdef PC_ALIGN_CHECK_EN
    , .adel_o     (gen_adel)
`endif
  );

  assign taken   = br_valid_i & gen_taken;
  assign advance = fetch_ack_i & ~stall_i & fetch_req_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_pc_d   = pend_pc_q;
    fetch_req_d = 1'b1;
    redirect_d  = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    adel_d      = 1'b0;
`endif
    case (state_q)
      ST_RUN: begin
        // A stalled branch is not captured; it is re-evaluated with fresh forwarded operands.
        if (taken && !stall_i) begin
          redirect_d = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
          adel_d     = gen_adel;
`endif
          if (advance) begin
            pc_d = gen_target;
          end else begin
            pend_pc_d = gen_target;
            state_d   = ST_PEND;
          end
        end else if (advance) begin
          pc_d = pc_q + 32'd4;
        end
      end
      ST_PEND: begin
        if (advance) begin
          pc_d    = pend_pc_q;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      pend_pc_q   <= '0;
      fetch_req_q <= 1'b0;
      redirect_q  <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      adel_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_pc_q   <= pend_pc_d;
      fetch_req_q <= fetch_req_d;
      redirect_q  <= redirect_d;
`ifdef PC_ALIGN_CHECK_EN
      adel_q      <= adel_d;
`endif
    end
  end

  assign pc_o        = pc_q;
  assign fetch_req_o = fetch_req_q;
  assign redirect_o  = redirect_q;
  assign link_o      = id_pc_i + 32'd8;
`ifdef PC_ALIGN_CHECK_EN
  assign adel_o      = adel_q;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit: directed vector table, reset corner case,
// and randomized traffic against a behavioural model of the PC rules.
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_ack_i, stall_i, br_valid_i, equal_i;
  logic [2:0]  br_type_i;
  logic [31:0] id_pc_i, rs_val_i;
  logic [15:0] imm16_i;
  logic [25:0] instr_index_i;
  logic [31:0] pc_o, link_o;
  logic        fetch_req_o, redirect_o;
`ifdef PC_ALIGN_CHECK_EN
  logic        adel_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_redirect_unit #(
    .RESET_PC (32'h0000_3000),
    .EXC_ENTRY(32'h0000_4180)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .fetch_ack_i  (fetch_ack_i),
    .stall_i      (stall_i),
    .br_valid_i   (br_valid_i),
    .br_type_i    (br_type_i),
    .equal_i      (equal_i),
    .id_pc_i      (id_pc_i),
    .imm16_i      (imm16_i),
    .instr_index_i(instr_index_i),
    .rs_val_i     (rs_val_i),
    .pc_o         (pc_o),
    .fetch_req_o  (fetch_req_o),
    .redirect_o   (redirect_o),
    .link_o       (link_o)
`ifdef PC_ALIGN_CHECK_EN
    , .adel_o     (adel_o)
`endif
  );

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc;
  logic        m_req, m_redir, m_adel;
  logic [31:0] m_pend[$];

  task automatic model_reset();
    m_pc    = 32'h0000_3000;
    m_req   = 1'b0;
    m_redir = 1'b0;
    m_adel  = 1'b0;
    m_pend.delete();
  endtask

  task automatic model_edge();
    bit          tk, misal, adv;
    logic [31:0] tgt;
    int          off;
    tk    = 0;
    misal = 0;
    tgt   = 0;
    off   = $signed(imm16_i) * 4;
    case (br_type_i)
      3'd1: begin tk = equal_i;  tgt = id_pc_i + 4 + off; end
      3'd2: begin tk = !equal_i; tgt = id_pc_i + 4 + off; end
      3'd3, 3'd4: begin
        tk  = 1;
        tgt = ((id_pc_i + 4) & 32'hF000_0000) | ({6'd0, instr_index_i} * 4);
      end
      3'd5: begin
        tk    = 1;
        misal = (rs_val_i % 4) != 0;
`ifdef PC_ALIGN_CHECK_EN
        tgt   = misal ? 32'h0000_4180 : rs_val_i;
`else
        tgt   = rs_val_i - (rs_val_i % 4);
`endif
      end
      default: tk = 0;
    endcase
    tk      = tk && br_valid_i;
    adv     = fetch_ack_i && !stall_i && m_req;
    m_redir = 0;
    m_adel  = 0;
    if (m_pend.size() != 0) begin
      if (adv) m_pc = m_pend.pop_front();
    end else if (tk && !stall_i) begin
      m_redir = 1;
      m_adel  = misal;
      if (adv) m_pc = tgt;
      else     m_pend.push_back(tgt);
    end else if (adv) begin
      m_pc = m_pc + 4;
    end
    m_req = 1;
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ack, input logic stall, input logic valid,
                       input logic [2:0] typ, input logic eq, input logic [31:0] id_pc,
                       input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] rs);
    fetch_ack_i   = ack;
    stall_i       = stall;
    br_valid_i    = valid;
    br_type_i     = typ;
    equal_i       = eq;
    id_pc_i       = id_pc;
    imm16_i       = imm;
    instr_index_i = idx;
    rs_val_i      = rs;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"},        pc_o,        m_pc);
    check({tag, ".fetch_req"}, {31'd0, fetch_req_o}, {31'd0, m_req});
    check({tag, ".redirect"},  {31'd0, redirect_o},  {31'd0, m_redir});
    check({tag, ".link"},      link_o,      id_pc_i + 32'd8);
`ifdef PC_ALIGN_CHECK_EN
    check({tag, ".adel"},      {31'd0, adel_o},      {31'd0, m_adel});
`endif
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        ack, stall, valid;
    logic [2:0]  typ;
    logic        eq;
    logic [31:0] id_pc;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] rs;
    logic [31:0] exp_pc;
    logic        exp_redir;
  } vec_t;

  function automatic vec_t mk(input logic ack, input logic stall, input logic valid,
                              input logic [2:0] typ, input logic eq, input logic [31:0] id_pc,
                              input logic [15:0] imm, input logic [25:0] idx,
                              input logic [31:0] rs, input logic [31:0] exp_pc,
                              input logic exp_redir);
    vec_t v;
    v.ack = ack; v.stall = stall; v.valid = valid; v.typ = typ; v.eq = eq;
    v.id_pc = id_pc; v.imm = imm; v.idx = idx; v.rs = rs;
    v.exp_pc = exp_pc; v.exp_redir = exp_redir;
    return v;
  endfunction

  localparam int NVEC = 14;
  vec_t tbl[NVEC];

  initial begin
    tbl[0]  = mk(1, 0, 0, 3'd0, 0, 32'h3000, 16'h0000, 26'h0,     32'h0,    32'h3000, 0);
    tbl[1]  = mk(1, 0, 0, 3'd0, 0, 32'h3000, 16'h0000, 26'h0,     32'h0,    32'h3004, 0);
    tbl[2]  = mk(1, 0, 0, 3'd0, 0, 32'h3000, 16'h0000, 26'h0,     32'h0,    32'h3008, 0);
    tbl[3]  = mk(1, 0, 1, 3'd1, 1, 32'h3004, 16'h0003, 26'h0,     32'h0,    32'h3014, 1);
    tbl[4]  = mk(1, 0, 1, 3'd1, 0, 32'h3004, 16'h0003, 26'h0,     32'h0,    32'h3018, 0);
    tbl[5]  = mk(0, 0, 1, 3'd2, 0, 32'h3010, 16'hFFFE, 26'h0,     32'h0,    32'h3018, 1);
    tbl[6]  = mk(0, 0, 0, 3'd0, 0, 32'h3014, 16'h0000, 26'h0,     32'h0,    32'h3018, 0);
    tbl[7]  = mk(1, 0, 0, 3'd0, 0, 32'h3014, 16'h0000, 26'h0,     32'h0,    32'h300C, 0);
    tbl[8]  = mk(1, 1, 1, 3'd5, 0, 32'h3000, 16'h0000, 26'h0,     32'h3100, 32'h300C, 0);
    tbl[9]  = mk(1, 1, 1, 3'd5, 0, 32'h3000, 16'h0000, 26'h0,     32'h3100, 32'h300C, 0);
    tbl[10] = mk(1, 0, 1, 3'd5, 0, 32'h3000, 16'h0000, 26'h0,     32'h3200, 32'h3200, 1);
    tbl[11] = mk(1, 0, 1, 3'd4, 0, 32'h3008, 16'h0000, 26'h0000C40, 32'h0,  32'h3100, 1);
`ifdef PC_ALIGN_CHECK_EN
    tbl[12] = mk(1, 0, 1, 3'd5, 0, 32'h3100, 16'h0000, 26'h0,     32'h3102, 32'h4180, 1);
    tbl[13] = mk(1, 0, 0, 3'd0, 0, 32'h3100, 16'h0000, 26'h0,     32'h0,    32'h4184, 0);
`else
    tbl[12] = mk(1, 0, 1, 3'd5, 0, 32'h3100, 16'h0000, 26'h0,     32'h3102, 32'h3100, 1);
    tbl[13] = mk(1, 0, 0, 3'd0, 0, 32'h3100, 16'h0000, 26'h0,     32'h0,    32'h3104, 0);
`endif
  end

  // ---------------- main sequence ----------------
  initial begin
    reset_n = 1'b0;
    drive(1, 0, 0, 3'd0, 0, 32'h3000, 16'h0, 26'h0, 32'h0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset.pc",        pc_o, 32'h3000);
    check("reset.fetch_req", {31'd0, fetch_req_o}, 32'd0);
    check("reset.redirect",  {31'd0, redirect_o},  32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int unsigned i = 0; i < NVEC; i++) begin
      drive(tbl[i].ack, tbl[i].stall, tbl[i].valid, tbl[i].typ, tbl[i].eq,
            tbl[i].id_pc, tbl[i].imm, tbl[i].idx, tbl[i].rs);
      step();
      check($sformatf("vec%0d.pc", i),       pc_o, tbl[i].exp_pc);
      check($sformatf("vec%0d.redirect", i), {31'd0, redirect_o}, {31'd0, tbl[i].exp_redir});
      check($sformatf("vec%0d.fetch_req", i), {31'd0, fetch_req_o}, 32'd1);
      check($sformatf("vec%0d.link", i),     link_o, tbl[i].id_pc + 32'd8);
`ifdef PC_ALIGN_CHECK_EN
      check($sformatf("vec%0d.adel", i), {31'd0, adel_o}, {31'd0, (i == 12)});
`endif
    end
    check("jal.link", link_o, 32'h3108);

    // Enter PEND, then reset asynchronously mid-cycle: pending target must be dropped.
    drive(0, 0, 1, 3'd2, 0, 32'h3010, 16'hFFFE, 26'h0, 32'h0);
    step();
    check_model("pend_enter");
    drive(1, 0, 0, 3'd0, 0, 32'h3010, 16'h0, 26'h0, 32'h0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset.pc",        pc_o, 32'h3000);
    check("async_reset.fetch_req", {31'd0, fetch_req_o}, 32'd0);
    check("async_reset.redirect",  {31'd0, redirect_o},  32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("post_reset0.pc", pc_o, 32'h3000);
    step();
    check("post_reset1.pc", pc_o, 32'h3004);

    // Randomized traffic against the model.
    for (int unsigned n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
            3'($urandom_range(0, 7)), $urandom_range(0, 1),
            32'h3000 + ($urandom_range(0, 255) * 4),
            16'($urandom), 26'($urandom),
            ($urandom_range(0, 3) == 0) ? $urandom : (32'h3000 + $urandom_range(0, 1023)));
      step();
      check_model($sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Owns the program counter for the 5-stage MIPS pipeline.
- Resolves branch and jump outcomes issued from ID, using the ID-stage operand-equality flag, and computes the next fetch address with MIPS delay-slot semantics.
- Remembers a redirect decided while the instruction fetch is still outstanding, so ID may retire the branch before IMEM answers.

Parameters:
- RESET_PC, 32'h0000_3000: PC value on reset.
- EXC_ENTRY, 32'h0000_4180: handler address used by the optional alignment check.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fetch_ack_i  in  1  IMEM has returned the instruction at pc_o this cycle.
- stall_i  in  1  hazard unit holds IF and ID this cycle.
- br_valid_i  in  1  control-flow instruction present in ID.
- br_type_i  in  3  0 NONE, 1 BEQ, 2 BNE, 3 J, 4 JAL, 5 JR.
- equal_i  in  1  ID operands equal (forwarded values).
- id_pc_i  in  32  PC of the instruction in ID.
- imm16_i  in  16  branch offset.
- instr_index_i  in  26  J/JAL index field.
- rs_val_i  in  32  forwarded rs value for JR.
- pc_o  out  32  current fetch address.
- fetch_req_o  out  1  fetch request to IMEM.
- redirect_o  out  1  one-cycle pulse when a taken redirect is accepted.
- link_o  out  32  id_pc_i+8, used by JAL writeback.

Behaviour:
- Reset (async, reset_n=0):
  - pc_o=RESET_PC, state=RUN, pend_pc=0.
  - redirect_o=0, fetch_req_o=0.
  - fetch_req_o goes to 1 on the first clk edge after reset_n rises and stays 1 afterwards.
- taken = br_valid_i & (BEQ&equal_i | BNE&~equal_i | J | JAL | JR). BNE/BEQ with br_valid_i=0 is never taken.
- Targets, all 32-bit, wrap modulo 2^32:
  - BEQ/BNE: id_pc_i + 4 + (sext(imm16_i) << 2).
  - J/JAL: {id_pc_i+4 [31:28], instr_index_i, 2'b00}.
  - JR: rs_val_i.
- advance = fetch_ack_i & ~stall_i & fetch_req_o.
- State RUN:
  - taken & advance: pc<=target, redirect_o=1. The delay slot is the instruction fetched this cycle.
  - taken & ~stall_i & ~advance: pend_pc<=target, go to PEND, redirect_o=1. The branch leaves ID.
  - taken & stall_i: no capture. The branch is re-presented and re-evaluated next cycle, because operands may change via forwarding.
  - ~taken & advance: pc<=pc+4.
  - otherwise: hold.
- State PEND:
  - advance: pc<=pend_pc, go to RUN.
  - br_valid_i while in PEND is ignored. Legal sequencing never produces it, because the delay slot is still undelivered.
- Latency: redirect visible on pc_o one cycle after the accepting edge.
- link_o is combinational.
- Reset mid-PEND discards pend_pc.

Optional Feature:
- Macro PC_ALIGN_CHECK_EN.
- Defined:
  - A taken JR with rs_val_i[1:0]!=0 redirects to EXC_ENTRY instead of rs_val_i.
  - Adds output adel_o, a one-cycle pulse on the accepting edge and 0 on reset.
  - The same applies to a PEND capture: pend_pc<=EXC_ENTRY.
- Undefined: the JR target is {rs_val_i[31:2], 2'b00}, and there is no adel_o port.

Decomposition:
- Package pc_pkg holds:
  - br_type_t encoding (NONE..JR).
  - state_t (RUN, PEND).
  - Defaults RESET_PC_DEF and EXC_ENTRY_DEF.
- Sub-module branch_target_gen is purely combinational: inputs are br_type, equal, id_pc, imm16, instr_index, rs_val; outputs are taken and target.
- The top-level module holds the PC register, pend_pc and the FSM.

Test Plan:
- Reset release, fetch_ack_i=1 every cycle, no branches -> pc_o goes 0x3000, 0x3004, 0x3008; fetch_req_o=0 during reset and 1 from the first edge after release.
- BEQ at id_pc_i=0x3004, imm16=0x0003, equal_i=1, advance=1 -> pc_o=0x3014 next cycle and redirect_o pulses. The same with equal_i=0 -> pc_o=pc+4 and no pulse.
- BNE, imm16=0xFFFE, id_pc_i=0x3010, equal_i=0, fetch_ack_i=0 -> state PEND with pend_pc=0x300C. Then fetch_ack_i=1 two cycles later -> pc_o=0x300C.
- JR rs_val=0x3100 with stall_i=1 for 2 cycles, then rs_val=0x3200 with stall_i=0 -> pc_o=0x3200; there is no capture of 0x3100.
- JAL id_pc_i=0x3008, index=0x0000C40 -> pc_o=0x00003100 and link_o=0x3010. reset_n pulsed low while in PEND -> pc_o=0x3000 immediately (asynchronous) and state RUN.
- PC_ALIGN_CHECK_EN defined: JR rs_val=0x3102 -> pc_o=0x4180 and adel_o=1 for one cycle. Undefined: pc_o=0x3100.
